// File: rtl/key_capture_if.sv
// Keypad capture bundle: scan inputs from the matrix scanner, queued key codes out.
// master = the capture stage, slave = scanner/consumer side.
interface key_capture_if;
   logic [3:0] columnas;
   logic [3:0] sample;
   logic       key_ready;
   logic       key_valid;
   logic [3:0] key_code;
   logic       key_held;
   logic       overflow;

   modport master (
      input  columnas,
      input  sample,
      input  key_ready,
      output key_valid,
      output key_code,
      output key_held,
      output overflow
   );

   modport slave (
      output columnas,
      output sample,
      output key_ready,
      input  key_valid,
      input  key_code,
      input  key_held,
      input  overflow
   );
endinterface

// File: rtl/key_capture.sv
// Confirms one key over STABLE_SCANS scans, encodes 4*row+col, queues it; valid 1 cycle after the confirming scan end.
// Backpressure: key_ready pops the head; a confirm into a full queue without a pop is dropped and sets sticky overflow.
module key_capture #(
   parameter int SETTLE_CYCLES = 4,
   parameter int STABLE_SCANS  = 3,
   parameter int FIFO_DEPTH    = 4
) (
   input logic           clk,
   input logic           n_reset,
   key_capture_if.master kif
);

   localparam int SW = $clog2(SETTLE_CYCLES + 2);
   localparam int CW = $clog2(STABLE_SCANS + 2);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int NW = PW + 1;

   localparam logic [SW-1:0] SETTLE_N = SW'(SETTLE_CYCLES);
   localparam logic [CW-1:0] STABLE_N = CW'(STABLE_SCANS);
   localparam logic [NW-1:0] DEPTH_N  = NW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CONFIRM,
      ST_HELD,
      ST_RELEASE
   } state_t;

   logic [3:0]    col_q;
   logic [SW-1:0] settle_q, settle_d;
   logic          hit_q, hit_d;
   logic          multi_q, multi_d;
   logic [3:0]    rec_code_q, rec_code_d;

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic [3:0]    cand_q;
   logic          held_q;

   logic [3:0]    mem_q [FIFO_DEPTH];
   logic [PW-1:0] wr_q, wr_d;
   logic [PW-1:0] rd_q, rd_d;
   logic [NW-1:0] count_q, count_d;
   logic          valid_q;
   logic [3:0]    head_q, head_d;
   logic          ovf_q;

   logic          col_onehot, col_chg, qualify, scan_end;
   logic          samp_one, samp_many;
   logic [1:0]    col_idx, row_idx;
   logic [3:0]    hit_code;
   logic          res_empty, res_key;
   logic [CW-1:0] cnt_inc;
   logic          push, pop, full, do_wr;

   // The column-change cycle itself never qualifies, so a fresh column always starts inside the settle window.
   assign col_onehot = $onehot(kif.columnas);
   assign col_chg    = (kif.columnas != col_q);
   assign qualify    = col_onehot && !col_chg && (settle_q >= SETTLE_N);
   assign scan_end   = (col_q == 4'b0001) && (kif.columnas == 4'b1000);
   assign samp_one   = $onehot(kif.sample);
   assign samp_many  = (kif.sample != 4'b0000) && !samp_one;

   always_comb begin
      case (kif.columnas)
         4'b1000: col_idx = 2'd0;
         4'b0100: col_idx = 2'd1;
         4'b0010: col_idx = 2'd2;
         default: col_idx = 2'd3;
      endcase
      case (kif.sample)
         4'b0001: row_idx = 2'd0;
         4'b0010: row_idx = 2'd1;
         4'b0100: row_idx = 2'd2;
         default: row_idx = 2'd3;
      endcase
   end

   assign hit_code = {row_idx, col_idx};

   always_comb begin
      settle_d = settle_q;
      if (!col_onehot || col_chg) begin
         settle_d = '0;
      end else if (settle_q < SETTLE_N) begin
         settle_d = settle_q + SW'(1);
      end
   end

   always_comb begin
      hit_d      = hit_q;
      multi_d    = multi_q;
      rec_code_d = rec_code_q;
      if (scan_end) begin
         hit_d      = 1'b0;
         multi_d    = 1'b0;
         rec_code_d = 4'd0;
      end else if (qualify) begin
         if (samp_many) begin
            multi_d = 1'b1;
         end else if (samp_one) begin
            if (!hit_q) begin
               hit_d      = 1'b1;
               rec_code_d = hit_code;
            end else if (hit_code != rec_code_q) begin
               multi_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         col_q      <= 4'b0000;
         settle_q   <= '0;
         hit_q      <= 1'b0;
         multi_q    <= 1'b0;
         rec_code_q <= 4'd0;
      end else begin
         col_q      <= kif.columnas;
         settle_q   <= settle_d;
         hit_q      <= hit_d;
         multi_q    <= multi_d;
         rec_code_q <= rec_code_d;
      end
   end

   assign res_empty = !hit_q && !multi_q;
   assign res_key   = hit_q && !multi_q;
   assign cnt_inc   = cnt_q + CW'(1);

   assign push = scan_end && res_key &&
                 (((state_q == ST_IDLE) && (STABLE_SCANS == 1)) ||
                  ((state_q == ST_CONFIRM) && (rec_code_q == cand_q) && (cnt_inc == STABLE_N)));

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         cand_q  <= 4'd0;
         held_q  <= 1'b0;
      end else if (scan_end) begin
         case (state_q)
            ST_IDLE: begin
               if (res_key) begin
                  if (STABLE_SCANS == 1) begin
                     state_q <= ST_HELD;
                     held_q  <= 1'b1;
                  end else begin
                     state_q <= ST_CONFIRM;
                     cand_q  <= rec_code_q;
                     cnt_q   <= CW'(1);
                  end
               end
            end
            ST_CONFIRM: begin
               if (res_key && (rec_code_q == cand_q)) begin
                  if (cnt_inc == STABLE_N) begin
                     state_q <= ST_HELD;
                     held_q  <= 1'b1;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_inc;
                  end
               end else if (res_key) begin
                  cand_q <= rec_code_q;
                  cnt_q  <= CW'(1);
               end else begin
                  state_q <= ST_IDLE;
                  cnt_q   <= '0;
               end
            end
            ST_HELD: begin
               // Any key or multi-key scan keeps the hold; a second key while held is never reported.
               if (res_empty) begin
                  if (STABLE_SCANS == 1) begin
                     state_q <= ST_IDLE;
                     held_q  <= 1'b0;
                     cnt_q   <= '0;
                  end else begin
                     state_q <= ST_RELEASE;
                     cnt_q   <= CW'(1);
                  end
               end
            end
            default: begin
               if (res_empty) begin
                  if (cnt_inc == STABLE_N) begin
                     state_q <= ST_IDLE;
                     held_q  <= 1'b0;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_inc;
                  end
               end else begin
                  state_q <= ST_HELD;
                  cnt_q   <= '0;
               end
            end
         endcase
      end
   end

   assign pop   = valid_q && kif.key_ready;
   assign full  = (count_q == DEPTH_N);
   assign do_wr = push && (!full || pop);

   always_comb begin
      count_d = count_q;
      if (do_wr && !pop) begin
         count_d = count_q + NW'(1);
      end else if (!do_wr && pop) begin
         count_d = count_q - NW'(1);
      end
      wr_d = do_wr ? wr_q + PW'(1) : wr_q;
      rd_d = pop ? rd_q + PW'(1) : rd_q;
      // Head is registered: forward the incoming code when it lands in the slot about to become the head.
      head_d = head_q;
      if (count_d != '0) begin
         head_d = (do_wr && (wr_q == rd_d)) ? rec_code_q : mem_q[rd_d];
      end
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= 4'd0;
         end
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         valid_q <= 1'b0;
         head_q  <= 4'd0;
         ovf_q   <= 1'b0;
      end else begin
         if (do_wr) begin
            mem_q[wr_q] <= rec_code_q;
         end
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
         valid_q <= (count_d != '0);
         head_q  <= head_d;
         if (push && full && !pop) begin
            ovf_q <= 1'b1;
         end
      end
   end

   assign kif.key_valid = valid_q;
   assign kif.key_code  = head_q;
   assign kif.key_held  = held_q;
   assign kif.overflow  = ovf_q;

endmodule

// File: tb/tb_key_capture.sv
// Random and directed keypad scans against a per-scan behavioural model; outputs compared every cycle.
module tb_key_capture;
   localparam int DEPTH  = 4;
   localparam int STABLE = 3;

   logic clk = 1'b0;
   logic n_reset;

   key_capture_if kif ();

   key_capture dut (
      .clk     (clk),
      .n_reset (n_reset),
      .kif     (kif)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // Model: scan result = number of active switches across the whole scan (0 empty, 1 key, >1 multi).
   int         mq[$];
   bit         m_ovf;
   int         m_state;  // 0 idle, 1 confirm, 2 held, 3 release
   int         m_cand;
   int         m_cnt;
   logic [3:0] scan_bits [4];
   logic [3:0] col_prev;

   int dut_popped[$];
   int vld_cycles;
   int se_cnt;
   int rdy_mode;
   int rdy_target;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("valid", int'(kif.key_valid), int'(mq.size() != 0));
         chk("held", int'(kif.key_held), int'(m_state >= 2));
         chk("overflow", int'(kif.overflow), int'(m_ovf));
         if (mq.size() != 0) chk("code", int'(kif.key_code), mq[0]);
      end
   end

   function automatic void model_scan(output bit push, output int code);
      int nbits = 0;
      int c     = 0;
      push = 1'b0;
      code = 0;
      for (int col = 0; col < 4; col++)
         for (int r = 0; r < 4; r++)
            if (scan_bits[col][r]) begin
               nbits++;
               c = 4 * r + col;
            end
      case (m_state)
         0: if (nbits == 1) begin
               if (STABLE == 1) begin push = 1'b1; code = c; m_state = 2; end
               else begin m_cand = c; m_cnt = 1; m_state = 1; end
            end
         1: if (nbits == 1 && c == m_cand) begin
               m_cnt++;
               if (m_cnt == STABLE) begin push = 1'b1; code = c; m_state = 2; end
            end else if (nbits == 1) begin
               m_cand = c; m_cnt = 1;
            end else begin
               m_state = 0;
            end
         2: if (nbits == 0) begin m_state = 3; m_cnt = 1; end
         default: if (nbits == 0) begin
               m_cnt++;
               if (m_cnt == STABLE) m_state = 0;
            end else begin
               m_state = 2;
            end
      endcase
   endfunction

   task automatic tick();
      bit se, pop, push;
      int code, sz;
      se = n_reset && col_prev == 4'b0001 && kif.columnas == 4'b1000;
      case (rdy_mode)
         0:       kif.key_ready = 1'b0;
         1:       kif.key_ready = 1'b1;
         2:       kif.key_ready = 1'($urandom_range(0, 1));
         default: kif.key_ready = se && (se_cnt == rdy_target);
      endcase
      if (kif.key_valid) vld_cycles++;
      if (kif.key_valid && kif.key_ready) dut_popped.push_back(int'(kif.key_code));
      @(posedge clk);
      #1;
      if (n_reset) begin
         sz   = mq.size();
         pop  = (sz != 0) && kif.key_ready;
         push = 1'b0;
         code = 0;
         if (se) begin
            model_scan(push, code);
            se_cnt++;
         end
         if (pop) void'(mq.pop_front());
         if (push) begin
            if (sz == DEPTH && !pop) m_ovf = 1'b1;
            else mq.push_back(code);
         end
         col_prev = kif.columnas;
      end else begin
         col_prev = 4'b0000;
      end
   endtask

   // Each column lasts 100 cycles; the first 3 carry garbage rows that the settle window must hide.
   task automatic do_scan(input logic [15:0] s);
      for (int c = 0; c < 4; c++) begin
         kif.columnas = 4'b1000 >> c;
         for (int i = 0; i < 100; i++) begin
            if (i < 3) kif.sample = 4'($urandom);
            else kif.sample = s[4*c +: 4];
            if (i == 3) scan_bits[c] = s[4*c +: 4];
            tick();
         end
      end
   endtask

   task automatic press(input int code, input int n);
      logic [15:0] s;
      s = '0;
      s[4 * (code % 4) + code / 4] = 1'b1;
      repeat (n) do_scan(s);
   endtask

   task automatic empty(input int n);
      repeat (n) do_scan(16'h0000);
   endtask

   task automatic do_reset();
      n_reset      = 1'b0;
      rdy_mode     = 0;
      kif.columnas = 4'b0000;
      mq.delete();
      m_ovf   = 1'b0;
      m_state = 0;
      m_cnt   = 0;
      m_cand  = 0;
      for (int c = 0; c < 4; c++) scan_bits[c] = 4'b0000;
      col_prev = 4'b0000;
      for (int i = 0; i < 8; i++) begin
         kif.sample = 4'($urandom);
         tick();
      end
      chk("reset_valid", int'(kif.key_valid), 0);
      chk("reset_code", int'(kif.key_code), 0);
      chk("reset_held", int'(kif.key_held), 0);
      chk("reset_overflow", int'(kif.overflow), 0);
      n_reset = 1'b1;
      dut_popped.delete();
      vld_cycles = 0;
   endtask

   task automatic chk_popped(input string name, input int n, input logic [19:0] codes);
      chk({name, "_count"}, dut_popped.size(), n);
      for (int k = 0; k < n && k < dut_popped.size(); k++)
         chk({name, "_entry"}, dut_popped[k], int'(codes[4*k +: 4]));
   endtask

   initial begin
      n_reset       = 1'b0;
      kif.columnas  = 4'b0000;
      kif.sample    = 4'b0000;
      kif.key_ready = 1'b0;
      rdy_mode      = 0;
      rdy_target    = 0;
      se_cnt        = 0;
      vld_cycles    = 0;
      m_state       = 0;
      m_ovf         = 1'b0;
      col_prev      = 4'b0000;
      chk_en        = 1'b1;

      // Idle after reset
      do_reset();
      empty(10);
      chk("idle_valid_cycles", vld_cycles, 0);

      // Single press, consumer always ready
      rdy_mode = 1;
      press(0, 3);
      empty(1);
      chk("single_held", int'(kif.key_held), 1);
      chk("single_pulse", vld_cycles, 1);
      chk_popped("single_pop", 1, 20'h00000);
      empty(3);
      chk("single_released", int'(kif.key_held), 0);

      // Bounce: 2 scans, gap, 3 stable scans
      rdy_mode = 0;
      dut_popped.delete();
      press(5, 2);
      empty(1);
      press(5, 3);
      empty(4);
      chk("bounce_model_count", mq.size(), 1);
      chk("bounce_code", int'(kif.key_code), 5);
      rdy_mode = 1;
      empty(1);
      chk_popped("bounce_pop", 1, 20'h00005);

      // Multi-key scan then row 3 on column 0001
      rdy_mode = 0;
      dut_popped.delete();
      do_scan(16'h0300);
      press(15, 3);
      empty(4);
      chk("multi_model_count", mq.size(), 1);
      chk("multi_code", int'(kif.key_code), 15);
      rdy_mode = 1;
      empty(1);
      chk_popped("multi_pop", 1, 20'h0000F);

      // Overflow: five presses into a four-deep queue
      do_reset();
      for (int k = 0; k < 5; k++) begin
         press(k, 3);
         empty(3);
      end
      empty(1);
      chk("ovf_flag", int'(kif.overflow), 1);
      chk("ovf_head", int'(kif.key_code), 0);
      chk("ovf_model_count", mq.size(), 4);
      rdy_mode = 1;
      empty(1);
      chk_popped("ovf_drain", 4, 20'h03210);

      // Full queue: pop coincides with the fifth confirm
      do_reset();
      for (int k = 0; k < 4; k++) begin
         press(k, 3);
         empty(3);
      end
      rdy_target = se_cnt + 3;
      rdy_mode   = 3;
      press(4, 3);
      empty(1);
      rdy_mode = 0;
      chk("full_pp_overflow", int'(kif.overflow), 0);
      chk("full_pp_head", int'(kif.key_code), 1);
      chk("full_pp_model_count", mq.size(), 4);
      chk_popped("full_pp_pop", 1, 20'h00000);
      rdy_mode = 1;
      empty(1);
      chk_popped("full_pp_drain", 5, 20'h43210);

      // Randomized scans with random consumer backpressure
      do_reset();
      rdy_mode = 2;
      for (int b = 0; b < 12; b++) begin
         case ($urandom_range(0, 2))
            0:       empty($urandom_range(1, 3));
            1:       press($urandom_range(0, 15), $urandom_range(1, 4));
            default: do_scan(16'($urandom));
         endcase
      end

      // Reset while a key is held with a queued code
      rdy_mode = 1;
      empty(4);
      rdy_mode = 0;
      press(7, 3);
      empty(1);
      chk("hold_before_reset", int'(kif.key_held), 1);
      chk("code_before_reset", int'(kif.key_code), 7);
      do_reset();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
